// File: rtl/rx_shift_register.sv
// UART receive front end: synchronises the serial line, validates the start bit,
// samples each bit at mid-bit LSB-first and strobes out the received word.
module rx_shift_register #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 rx_meta;
    logic                 rx_s;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;

    logic half_hit;
    logic full_hit;
    logic cnt_inc;
    logic cnt_clr;
    logic start_ok;
    logic shift_en;
    logic stop_sample;

    // NOTE: synchroniser flops reset to 1 so a reset never looks like a start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep the two stages a real two-flop pipeline.
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
        end
    end

    assign half_hit = baud_tick && (cnt == HALF_LAST);
    assign full_hit = baud_tick && (cnt == FULL_LAST);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            IDLE:      if (baud_tick && !rx_s)       state_next = START;
            START:     if (half_hit)                 state_next = rx_s ? IDLE : DATA;
            DATA:      if (full_hit && bit_idx == LAST_IDX) state_next = STOP;
            STOP:      if (full_hit)                 state_next = rx_s ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (baud_tick && rx_s)        state_next = IDLE;
            default:                                 state_next = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        rx_busy     = (state != IDLE);
        start_ok    = 1'b0;
        shift_en    = 1'b0;
        stop_sample = 1'b0;
        cnt_inc     = 1'b0;
        cnt_clr     = 1'b0;
        case (state)
            START: begin
                start_ok = half_hit && !rx_s;
                cnt_inc  = baud_tick && !half_hit;
                cnt_clr  = half_hit;
            end
            DATA: begin
                shift_en = full_hit;
                cnt_inc  = baud_tick && !full_hit;
                cnt_clr  = full_hit;
            end
            STOP: begin
                stop_sample = full_hit;
                cnt_inc     = baud_tick && !full_hit;
                cnt_clr     = full_hit;
            end
            default: begin
                cnt_clr = baud_tick;
            end
        endcase
    end

    // Oversample counter and bit index only move on baud ticks
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + 1'b1;
            end

            if (start_ok) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

    // LSB-first: each new bit enters at the top and walks down to bit 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg <= '0;
        end else if (shift_en) begin
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_valid     <= stop_sample;
            rx_frame_err <= stop_sample && !rx_s;
            if (stop_sample) begin
                rx_data <= shreg;
            end
        end
    end

endmodule

// File: tb/tb_rx_shift_register.sv
// Directed bench for rx_shift_register: good frames, false start, framing error,
// back-to-back frames, mid-frame reset and a baud-tick stall.
module tb_rx_shift_register;

    logic       clk;
    logic       reset;
    logic       baud_tick;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;

    logic       tick_en;
    logic [1:0] div;
    logic       mid_busy;
    logic       prev_valid;
    logic [7:0] d;

    int         total;
    int         bad;
    int         valid_cnt;
    int         wide_strobe;
    int         orphan_err;
    logic [7:0] data_hist[$];
    logic       err_hist[$];

    rx_shift_register #(
        .DATA_BITS (8),
        .OVERSAMPLE(16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .baud_tick   (baud_tick),
        .rx_in       (rx_in),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_frame_err(rx_frame_err),
        .rx_busy     (rx_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One baud tick every 4 clocks, gated by tick_en
    initial begin
        div       = 2'd0;
        baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            div       = div + 2'd1;
            baud_tick = tick_en && (div == 2'd0);
        end
    end

    initial begin
        valid_cnt   = 0;
        wide_strobe = 0;
        orphan_err  = 0;
        prev_valid  = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_valid) begin
                valid_cnt++;
                data_hist.push_back(rx_data);
                err_hist.push_back(rx_frame_err);
            end
            if (rx_valid && prev_valid) wide_strobe++;
            if (rx_frame_err && !rx_valid) orphan_err++;
            prev_valid = rx_valid;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] hist_data(input int i);
        if (i < data_hist.size()) return data_hist[i];
        return 'x;
    endfunction

    function automatic logic hist_err(input int i);
        if (i < err_hist.size()) return err_hist[i];
        return 1'bx;
    endfunction

    task automatic send_bit(input logic b, input int clks);
        rx_in = b;
        repeat (clks) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        send_bit(1'b0, 64);
        mid_busy = rx_busy;
        for (int i = 0; i < 8; i++) send_bit(data[i], 64);
        send_bit(stop_bit, 64);
    endtask

    task automatic wait_count(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (valid_cnt < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, valid_cnt, n);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b0;
        rx_in   = 1'b1;
        tick_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data",  rx_data,      8'h00);
        check("rst_valid", rx_valid,     1'b0);
        check("rst_err",   rx_frame_err, 1'b0);
        check("rst_busy",  rx_busy,      1'b0);
        reset = 1'b1;
        repeat (10) @(negedge clk);

        // 1: clean 0xA5
        send_frame(8'hA5, 1'b1);
        send_bit(1'b1, 32);
        wait_count("t1_count", 1, 64);
        check("t1_busy_mid", mid_busy,     1'b1);
        check("t1_data",     hist_data(0), 8'hA5);
        check("t1_err",      hist_err(0),  1'b0);
        check("t1_busy_end", rx_busy,      1'b0);

        // 2: 4-tick glitch must abort in START
        send_bit(1'b0, 16);
        check("t2_busy_glitch", rx_busy, 1'b1);
        send_bit(1'b1, 200);
        check("t2_count", valid_cnt, 1);
        check("t2_data",  rx_data,   8'hA5);
        check("t2_busy",  rx_busy,   1'b0);

        // 3: 0x3C with low stop bit, then line held low
        send_frame(8'h3C, 1'b0);
        wait_count("t3_count", 2, 64);
        check("t3_data",     hist_data(1), 8'h3C);
        check("t3_err",      hist_err(1),  1'b1);
        check("t3_busy_brk", rx_busy,      1'b1);
        send_bit(1'b0, 192);
        check("t3_busy_hold", rx_busy, 1'b1);
        send_bit(1'b1, 300);
        check("t3_busy_end", rx_busy,   1'b0);
        check("t3_no_extra", valid_cnt, 2);

        // 4: back-to-back 0x00 then 0xFF
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_bit(1'b1, 64);
        wait_count("t4_count", 4, 64);
        check("t4_data0", hist_data(2), 8'h00);
        check("t4_err0",  hist_err(2),  1'b0);
        check("t4_data1", hist_data(3), 8'hFF);
        check("t4_err1",  hist_err(3),  1'b0);

        // 5: reset during data bit 4, then receive 0x55
        d = 8'h96;
        send_bit(1'b0, 64);
        for (int i = 0; i < 4; i++) send_bit(d[i], 64);
        rx_in = d[4];
        repeat (32) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("t5_rst_data",  rx_data,      8'h00);
        check("t5_rst_valid", rx_valid,     1'b0);
        check("t5_rst_err",   rx_frame_err, 1'b0);
        check("t5_rst_busy",  rx_busy,      1'b0);
        rx_in = 1'b1;
        repeat (8) @(negedge clk);
        reset = 1'b1;
        repeat (100) @(negedge clk);
        check("t5_no_strobe", valid_cnt, 4);
        send_frame(8'h55, 1'b1);
        send_bit(1'b1, 64);
        wait_count("t5_count", 5, 64);
        check("t5_data", hist_data(4), 8'h55);
        check("t5_err",  hist_err(4),  1'b0);

        // 6: baud_tick stalled for 100 clk inside data bit 3 of 0xC3
        d = 8'hC3;
        send_bit(1'b0, 64);
        for (int i = 0; i < 3; i++) send_bit(d[i], 64);
        rx_in = d[3];
        repeat (32) @(negedge clk);
        tick_en = 1'b0;
        repeat (100) @(negedge clk);
        check("t6_busy_frozen", rx_busy,   1'b1);
        check("t6_no_strobe",   valid_cnt, 5);
        tick_en = 1'b1;
        repeat (32) @(negedge clk);
        for (int i = 4; i < 8; i++) send_bit(d[i], 64);
        send_bit(1'b1, 64);
        send_bit(1'b1, 64);
        wait_count("t6_count", 6, 64);
        check("t6_data",    hist_data(5), 8'hC3);
        check("t6_err",     hist_err(5),  1'b0);
        check("t6_rx_data", rx_data,      8'hC3);

        check("strobe_width", wide_strobe, 0);
        check("orphan_err",   orphan_err,  0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
